// File: rtl/spin_round_sequencer.sv
// Round sequencer for the LED roulette game: launches a spin, waits for the
// spinner, lets the result settle, evaluates the hit, asks the money manager
// to update and holds the result on display before closing the round.
module spin_round_sequencer #(
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned HOLD_CYCLES    = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 400_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       round_req,
   input  logic       abort,
   input  logic [2:0] bet_count,
   input  logic       spin_done,
   input  logic [2:0] result_pos,
   input  logic [2:0] hit_count,
   output logic       spin_start,
   output logic       update_req,
   output logic       round_done,
   output logic       bad_req,
   output logic       busy,
   output logic       win,
   output logic [2:0] latched_result,
   output logic [2:0] latched_bets,
   output logic       timeout_err,
   output logic [7:0] round_cnt
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LAUNCH,
      S_SPIN_WAIT,
      S_SETTLE,
      S_EVAL,
      S_UPDATE,
      S_HOLD,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] timer_inc;
   logic        bet_ok;

   logic        spin_start_q, spin_start_d;
   logic        update_req_q, update_req_d;
   logic        round_done_q, round_done_d;
   logic        bad_req_q, bad_req_d;
   logic        busy_q, busy_d;
   logic        win_q, win_d;
   logic        timeout_err_q, timeout_err_d;
   logic [2:0]  latched_result_q, latched_result_d;
   logic [2:0]  latched_bets_q, latched_bets_d;
   logic [7:0]  round_cnt_q, round_cnt_d;

   assign bet_ok    = (bet_count != 3'd0) && (bet_count <= 3'd4);
   assign timer_inc = timer_q + 32'd1;

   // Next state, shared phase timer and the next value of every registered output.
   always_comb begin
      // NOTE: every variable gets its default first, so no branch can leave one unassigned and infer a latch.
      state_d          = state_q;
      timer_d          = timer_q;
      win_d            = win_q;
      latched_result_d = latched_result_q;
      latched_bets_d   = latched_bets_q;
      round_cnt_d      = round_cnt_q;
      bad_req_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (round_req && !abort) begin
               if (bet_ok) begin
                  latched_bets_d = bet_count;
                  win_d          = 1'b0;
                  state_d        = S_LAUNCH;
               end else begin
                  bad_req_d = 1'b1;
               end
            end
         end
         S_LAUNCH: begin
            timer_d = '0;
            state_d = S_SPIN_WAIT;
         end
         S_SPIN_WAIT: begin
            // A spin_done on the timeout edge still counts as a good spin.
            if (spin_done) begin
               latched_result_d = result_pos;
               timer_d          = '0;
               state_d          = S_SETTLE;
            end else if (timer_inc == TIMEOUT_CYCLES - 1) begin
               timer_d = '0;
               state_d = S_ERROR;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_SETTLE: begin
            if (timer_q == SETTLE_CYCLES - 1) begin
               timer_d = '0;
               state_d = S_EVAL;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_EVAL: begin
            win_d   = (hit_count != 3'd0);
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            timer_d = '0;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (timer_q == HOLD_CYCLES - 1) begin
               timer_d = '0;
               state_d = S_DONE;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase

      // Abort outranks round_req, spin_done and timeout; a round already in DONE completes.
      if (abort) begin
         case (state_q)
            S_LAUNCH, S_SPIN_WAIT, S_SETTLE, S_EVAL, S_UPDATE, S_HOLD: begin
               state_d          = S_IDLE;
               timer_d          = '0;
               win_d            = 1'b0;
               latched_result_d = latched_result_q;
            end
            S_ERROR: begin
               state_d = S_IDLE;
               timer_d = '0;
            end
            default: ;
         endcase
      end

      if ((state_q == S_HOLD) && (state_d == S_DONE)) begin
         round_cnt_d = round_cnt_q + 8'd1;
      end

      // Pulses and flags follow the state being entered, so they line up with it.
      spin_start_d  = (state_d == S_LAUNCH);
      update_req_d  = (state_d == S_UPDATE);
      round_done_d  = (state_d == S_DONE);
      busy_d        = (state_d != S_IDLE) && (state_d != S_ERROR);
      timeout_err_d = (state_d == S_ERROR);
   end

   // State, timer and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q          <= S_IDLE;
         timer_q          <= '0;
         spin_start_q     <= 1'b0;
         update_req_q     <= 1'b0;
         round_done_q     <= 1'b0;
         bad_req_q        <= 1'b0;
         busy_q           <= 1'b0;
         win_q            <= 1'b0;
         timeout_err_q    <= 1'b0;
         latched_result_q <= '0;
         latched_bets_q   <= '0;
         round_cnt_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
         state_q          <= state_d;
         timer_q          <= timer_d;
         spin_start_q     <= spin_start_d;
         update_req_q     <= update_req_d;
         round_done_q     <= round_done_d;
         bad_req_q        <= bad_req_d;
         busy_q           <= busy_d;
         win_q            <= win_d;
         timeout_err_q    <= timeout_err_d;
         latched_result_q <= latched_result_d;
         latched_bets_q   <= latched_bets_d;
         round_cnt_q      <= round_cnt_d;
      end
   end

   assign spin_start     = spin_start_q;
   assign update_req     = update_req_q;
   assign round_done     = round_done_q;
   assign bad_req        = bad_req_q;
   assign busy           = busy_q;
   assign win            = win_q;
   assign timeout_err    = timeout_err_q;
   assign latched_result = latched_result_q;
   assign latched_bets   = latched_bets_q;
   assign round_cnt      = round_cnt_q;

endmodule

// File: tb/tb_spin_round_sequencer.sv
// Bench for spin_round_sequencer. Cycle n is the cycle that follows clock
// edge n-1; a round_req driven before edge 0 is therefore answered in cycle 1.
module tb_spin_round_sequencer;

   localparam int SETTLE = 2;
   localparam int HOLD   = 3;
   localparam int TO     = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       round_req, abort, spin_done;
   logic [2:0] bet_count, result_pos, hit_count;
   logic       spin_start, update_req, round_done, bad_req, busy, win, timeout_err;
   logic [2:0] latched_result, latched_bets;
   logic [7:0] round_cnt;
   logic [20:0] all_outs;

   spin_round_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .HOLD_CYCLES   (HOLD),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .round_req     (round_req),
      .abort         (abort),
      .bet_count     (bet_count),
      .spin_done     (spin_done),
      .result_pos    (result_pos),
      .hit_count     (hit_count),
      .spin_start    (spin_start),
      .update_req    (update_req),
      .round_done    (round_done),
      .bad_req       (bad_req),
      .busy          (busy),
      .win           (win),
      .latched_result(latched_result),
      .latched_bets  (latched_bets),
      .timeout_err   (timeout_err),
      .round_cnt     (round_cnt)
   );

   always #5 clk = ~clk;

   assign all_outs = {spin_start, update_req, round_done, bad_req, busy, win,
                      latched_result, latched_bets, timeout_err, round_cnt};

   int n_checks = 0;
   int n_pass   = 0;

   // Observations of one round, gathered by run_round.
   int o_spin_first, o_spin_cnt, o_upd_first, o_upd_cnt, o_done_first, o_done_cnt;
   int o_bad_first, o_bad_cnt, o_busy_cnt, o_err_first, o_multi;

   // Model of the architecturally visible latched state.
   logic       m_win;
   logic [2:0] m_lres, m_bets;
   logic [7:0] m_cnt;

   typedef struct {
      int         spin_cnt;
      int         upd;
      int         done;
      int         bad;
      int         busy;
      int         err;
      logic       win;
      logic       terr;
      logic [2:0] lres;
      logic [2:0] bets;
      logic [7:0] cnt;
   } exp_t;

   // Predict a round from the timing rules: SPIN_WAIT occupies cycles 2..TO,
   // update_req = spin edge + SETTLE + 2, round_done = update + HOLD + 1,
   // ERROR from cycle TO+1, and an abort at edge a truncates everything after cycle a.
   function automatic exp_t predict(int bets, int k, logic [2:0] res, logic [2:0] hit,
                                    int a, int n_edges);
      exp_t e;
      int   u, d;
      e.spin_cnt = 0; e.upd = -1; e.done = -1; e.bad = 0; e.busy = 0; e.err = -1;
      e.win = m_win; e.terr = 1'b0; e.lres = m_lres; e.bets = m_bets; e.cnt = m_cnt;
      if (bets < 1 || bets > 4) begin
         e.bad = 1;
         return e;
      end
      e.spin_cnt = 1;
      e.bets     = 3'(bets);
      e.win      = 1'b0;
      if (k >= 2 && k <= TO && (a < 0 || k < a)) begin
         u      = k + SETTLE + 2;
         d      = u + HOLD + 1;
         e.lres = res;
         if (a >= 1 && a < d) begin
            e.busy = a;
            if (u <= a) e.upd = u;
         end else begin
            e.upd  = u;
            e.done = d;
            e.busy = d;
            e.win  = (hit != 3'd0);
            e.cnt  = m_cnt + 8'd1;
         end
      end else if (a >= 1 && a <= TO) begin
         e.busy = a;
      end else begin
         e.busy = TO;
         e.err  = TO + 1;
         e.terr = !(a > TO && a < n_edges);
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one round (round_req before edge 0) and record what the DUT does.
   task automatic run_round(input int bets, input int k, input logic [2:0] res,
                            input logic [2:0] hit, input int a, input int req_e,
                            input int spur_e, input int n_edges);
      o_spin_first = -1; o_upd_first = -1; o_done_first = -1; o_bad_first = -1; o_err_first = -1;
      o_spin_cnt = 0; o_upd_cnt = 0; o_done_cnt = 0; o_bad_cnt = 0; o_busy_cnt = 0; o_multi = 0;
      hit_count = hit;
      for (int ed = 0; ed < n_edges; ed++) begin
         round_req  = (ed == 0) || (ed == req_e);
         bet_count  = 3'(bets);
         spin_done  = (ed == k) || (ed == spur_e);
         result_pos = (ed == k) ? res : ~res;
         abort      = (ed == a);
         tick();
         round_req = 1'b0; spin_done = 1'b0; abort = 1'b0;
         if (spin_start) begin o_spin_cnt++; if (o_spin_first < 0) o_spin_first = ed + 1; end
         if (update_req) begin o_upd_cnt++;  if (o_upd_first < 0)  o_upd_first  = ed + 1; end
         if (round_done) begin o_done_cnt++; if (o_done_first < 0) o_done_first = ed + 1; end
         if (bad_req)    begin o_bad_cnt++;  if (o_bad_first < 0)  o_bad_first  = ed + 1; end
         if (busy) o_busy_cnt++;
         if (timeout_err && o_err_first < 0) o_err_first = ed + 1;
         if (int'(spin_start) + int'(update_req) + int'(round_done) + int'(bad_req) > 1) o_multi++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; round_req = 1'b1; abort = 1'b0; bet_count = 3'd2;
      spin_done = 1'b0; result_pos = 3'd0; hit_count = 3'd0;
      tick();
      tick();
      n_checks++;
      if (all_outs !== 21'd0) $display("FAIL reset_outputs: got %h, expected 0", all_outs);
      else n_pass++;
      round_req = 1'b0;
      rst = 1'b1;
      tick();
      n_checks++;
      if (spin_start !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_no_launch: spin_start=%b busy=%b, expected 0 0", spin_start, busy);
      else n_pass++;
      m_win = 1'b0; m_lres = 3'd0; m_bets = 3'd0; m_cnt = 8'd0;
   endtask

   task automatic test_basic_round();
      run_round(2, 4, 3'd5, 3'd1, -1, -1, -1, 14);
      n_checks++;
      if (o_spin_first !== 1 || o_spin_cnt !== 1)
         $display("FAIL basic_spin_start: cycle %0d count %0d, expected cycle 1 count 1", o_spin_first, o_spin_cnt);
      else n_pass++;
      n_checks++;
      if (o_upd_first !== 8 || o_upd_cnt !== 1)
         $display("FAIL basic_update_req: cycle %0d count %0d, expected cycle 8 count 1", o_upd_first, o_upd_cnt);
      else n_pass++;
      n_checks++;
      if (o_done_first !== 12 || o_done_cnt !== 1)
         $display("FAIL basic_round_done: cycle %0d count %0d, expected cycle 12 count 1", o_done_first, o_done_cnt);
      else n_pass++;
      n_checks++;
      if (win !== 1'b1 || latched_result !== 3'd5 || latched_bets !== 3'd2 || round_cnt !== 8'd1)
         $display("FAIL basic_latched: win=%b result=%0d bets=%0d cnt=%0d, expected 1 5 2 1",
                  win, latched_result, latched_bets, round_cnt);
      else n_pass++;
      n_checks++;
      if (o_busy_cnt !== 12 || busy !== 1'b0 || o_multi !== 0)
         $display("FAIL basic_busy: busy cycles %0d final %b overlaps %0d, expected 12 0 0", o_busy_cnt, busy, o_multi);
      else n_pass++;
      m_win = 1'b1; m_lres = 3'd5; m_bets = 3'd2; m_cnt = 8'd1;
   endtask

   task automatic test_bad_req();
      int bad_vals[3] = '{0, 5, 7};
      foreach (bad_vals[i]) begin
         run_round(bad_vals[i], 3, 3'd1, 3'd1, -1, -1, -1, 6);
         n_checks++;
         if (o_bad_cnt !== 1 || o_bad_first !== 1)
            $display("FAIL bad_req_%0d: count %0d cycle %0d, expected count 1 cycle 1", bad_vals[i], o_bad_cnt, o_bad_first);
         else n_pass++;
         n_checks++;
         if (o_spin_cnt !== 0 || o_busy_cnt !== 0 || latched_bets !== m_bets || latched_result !== m_lres)
            $display("FAIL bad_req_quiet_%0d: spins %0d busy %0d bets %0d result %0d, expected 0 0 %0d %0d",
                     bad_vals[i], o_spin_cnt, o_busy_cnt, latched_bets, latched_result, m_bets, m_lres);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      run_round(3, -1, 3'd0, 3'd0, -1, 25, -1, 30);
      n_checks++;
      if (o_err_first !== TO + 1 || o_busy_cnt !== TO)
         $display("FAIL timeout_entry: error cycle %0d busy cycles %0d, expected %0d %0d",
                  o_err_first, o_busy_cnt, TO + 1, TO);
      else n_pass++;
      n_checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0 || o_spin_cnt !== 1 || o_upd_cnt !== 0 || o_done_cnt !== 0)
         $display("FAIL timeout_hold: err=%b busy=%b spins=%0d upd=%0d done=%0d, expected 1 0 1 0 0",
                  timeout_err, busy, o_spin_cnt, o_upd_cnt, o_done_cnt);
      else n_pass++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b0)
         $display("FAIL timeout_abort: err=%b busy=%b, expected 0 0", timeout_err, busy);
      else n_pass++;
      m_win = 1'b0; m_bets = 3'd3;
   endtask

   task automatic test_abort_settle();
      run_round(4, 3, 3'd2, 3'd3, 4, 2, -1, 16);
      n_checks++;
      if (o_busy_cnt !== 4 || o_spin_cnt !== 1 || o_upd_cnt !== 0 || o_done_cnt !== 0)
         $display("FAIL abort_settle_pulses: busy %0d spins %0d upd %0d done %0d, expected 4 1 0 0",
                  o_busy_cnt, o_spin_cnt, o_upd_cnt, o_done_cnt);
      else n_pass++;
      n_checks++;
      if (win !== 1'b0 || round_cnt !== m_cnt || latched_result !== 3'd2 || latched_bets !== 3'd4)
         $display("FAIL abort_settle_state: win=%b cnt=%0d result=%0d bets=%0d, expected 0 %0d 2 4",
                  win, round_cnt, latched_result, latched_bets, m_cnt);
      else n_pass++;
      m_win = 1'b0; m_lres = 3'd2; m_bets = 3'd4;
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         int         bets, k, a, req_e, spur_e;
         logic [2:0] res, hit;
         exp_t       e;
         if ($urandom_range(9, 0) == 0) begin
            bets = int'($urandom_range(3, 0));
            if (bets != 0) bets = bets + 4;
         end else begin
            bets = int'($urandom_range(4, 1));
         end
         k      = ($urandom_range(9, 0) < 7) ? int'($urandom_range(TO, 2)) : int'($urandom_range(24, 1));
         res    = 3'($urandom);
         hit    = 3'($urandom_range(4, 0));
         a      = ($urandom_range(9, 0) < 3) ? int'($urandom_range(30, 1)) : -1;
         req_e  = (bets >= 1 && bets <= 4 && a < 0) ? int'($urandom_range(10, 1)) : -1;
         spur_e = (k >= 2 && k <= TO) ? k + int'($urandom_range(6, 1)) : 1;
         e = predict(bets, k, res, hit, a, 32);
         run_round(bets, k, res, hit, a, req_e, spur_e, 32);
         n_checks++;
         if (o_spin_cnt !== e.spin_cnt || (e.spin_cnt == 1 && o_spin_first !== 1))
            $display("FAIL rnd%0d spin_start: count %0d cycle %0d, expected count %0d", it, o_spin_cnt, o_spin_first, e.spin_cnt);
         else n_pass++;
         n_checks++;
         if (o_upd_first !== e.upd || o_upd_cnt !== ((e.upd >= 0) ? 1 : 0))
            $display("FAIL rnd%0d update_req: cycle %0d count %0d, expected cycle %0d", it, o_upd_first, o_upd_cnt, e.upd);
         else n_pass++;
         n_checks++;
         if (o_done_first !== e.done || o_done_cnt !== ((e.done >= 0) ? 1 : 0))
            $display("FAIL rnd%0d round_done: cycle %0d count %0d, expected cycle %0d", it, o_done_first, o_done_cnt, e.done);
         else n_pass++;
         n_checks++;
         if (o_bad_cnt !== e.bad)
            $display("FAIL rnd%0d bad_req: count %0d, expected %0d", it, o_bad_cnt, e.bad);
         else n_pass++;
         n_checks++;
         if (o_busy_cnt !== e.busy || o_err_first !== e.err)
            $display("FAIL rnd%0d busy_err: busy %0d err cycle %0d, expected %0d %0d", it, o_busy_cnt, o_err_first, e.busy, e.err);
         else n_pass++;
         n_checks++;
         if (o_multi !== 0)
            $display("FAIL rnd%0d pulse_overlap: %0d cycles, expected 0", it, o_multi);
         else n_pass++;
         n_checks++;
         if (win !== e.win || timeout_err !== e.terr)
            $display("FAIL rnd%0d win_err: win=%b err=%b, expected %b %b", it, win, timeout_err, e.win, e.terr);
         else n_pass++;
         n_checks++;
         if (latched_result !== e.lres || latched_bets !== e.bets || round_cnt !== e.cnt)
            $display("FAIL rnd%0d latched: result %0d bets %0d cnt %0d, expected %0d %0d %0d",
                     it, latched_result, latched_bets, round_cnt, e.lres, e.bets, e.cnt);
         else n_pass++;
         m_win = e.win; m_lres = e.lres; m_bets = e.bets; m_cnt = e.cnt;
         if (e.terr) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
         end
      end
   endtask

   task automatic test_wrap();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      m_win = 1'b0; m_lres = 3'd0; m_bets = 3'd0; m_cnt = 8'd0;
      for (int i = 0; i < 256; i++) begin
         run_round(1 + i % 4, 2 + i % 3, 3'(i), 3'd0, -1, -1, -1, 14);
         m_cnt = m_cnt + 8'd1;
         n_checks++;
         if (win !== 1'b0 || round_cnt !== m_cnt || o_done_cnt !== 1)
            $display("FAIL wrap_round%0d: win=%b cnt=%0d done=%0d, expected 0 %0d 1", i, win, round_cnt, o_done_cnt, m_cnt);
         else n_pass++;
      end
      n_checks++;
      if (round_cnt !== 8'd0)
         $display("FAIL wrap_final: cnt=%0d, expected 0", round_cnt);
      else n_pass++;
      m_win = 1'b0; m_lres = 3'd7; m_bets = 3'd4;
   endtask

   task automatic test_reset_in_hold();
      int n_upd = 0, n_done = 0, n_spin = 0;
      run_round(2, 3, 3'd6, 3'd1, -1, -1, -1, 12);
      n_checks++;
      if (round_cnt !== m_cnt + 8'd1 || win !== 1'b1)
         $display("FAIL hold_pre_round: cnt=%0d win=%b, expected %0d 1", round_cnt, win, m_cnt + 8'd1);
      else n_pass++;
      hit_count = 3'd1;
      for (int ed = 0; ed < 9; ed++) begin
         round_req  = (ed == 0);
         bet_count  = 3'd3;
         spin_done  = (ed == 3);
         result_pos = 3'd4;
         tick();
         if (update_req) n_upd++;
         if (round_done) n_done++;
      end
      round_req = 1'b0; spin_done = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || n_upd !== 1 || n_done !== 0)
         $display("FAIL hold_reached: busy=%b upd=%0d done=%0d, expected 1 1 0", busy, n_upd, n_done);
      else n_pass++;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_checks++;
      if (all_outs !== 21'd0)
         $display("FAIL hold_reset_outputs: got %h, expected 0", all_outs);
      else n_pass++;
      n_upd = 0; n_done = 0;
      for (int ed = 0; ed < 8; ed++) begin
         tick();
         if (update_req) n_upd++;
         if (round_done) n_done++;
         if (spin_start) n_spin++;
      end
      n_checks++;
      if (n_upd !== 0 || n_done !== 0 || n_spin !== 0 || busy !== 1'b0)
         $display("FAIL hold_reset_quiet: upd=%0d done=%0d spin=%0d busy=%b, expected 0 0 0 0", n_upd, n_done, n_spin, busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_round();
      test_bad_req();
      test_timeout();
      test_abort_settle();
      test_random();
      test_wrap();
      test_reset_in_hold();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule

// File: doc/spin_round_sequencer.md
SPIN_ROUND_SEQUENCER -- requirements
Module: spin_round_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles waited after spin_done before hit evaluation (min 1).
REQ-002 SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning result-display cycles between update_req and round_done (min 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 400_000_000, meaning max cycles in SPIN_WAIT before error (min 2).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 round_req  in  1  one-cycle request from game FSM to run a round.
REQ-007 abort  in  1  cancel current round / clear error.
REQ-008 bet_count  in  3  numbers bet, legal 1..4.
REQ-009 spin_done  in  1  one-cycle pulse from LED spinner.
REQ-010 result_pos  in  3  spinner stop position, valid when spin_done=1.
REQ-011 hit_count  in  3  hit checker result, driven from latched_result.
REQ-012 spin_start  out  1  one-cycle pulse to LED spinner.
REQ-013 update_req  out  1  one-cycle pulse to money manager.
REQ-014 round_done  out  1  one-cycle pulse, round complete.
REQ-015 bad_req  out  1  one-cycle pulse, round_req rejected for illegal bet_count.
REQ-016 busy  out  1  high in every state except IDLE and ERROR.
REQ-017 win  out  1  latched win result of last evaluated round.
REQ-018 latched_result  out  3  result_pos captured at spin_done.
REQ-019 latched_bets  out  3  bet_count captured at acceptance.
REQ-020 timeout_err  out  1  sticky spinner-timeout flag.
REQ-021 round_cnt  out  8  completed-round counter.

Function
REQ-022 States SHALL be IDLE, LAUNCH, SPIN_WAIT, SETTLE, EVAL, UPDATE, HOLD, DONE, ERROR; all outputs registered.
REQ-023 IDLE: round_req=1 with bet_count in 1..4 -> LAUNCH, latched_bets<=bet_count, win<=0; bet_count 0 or 5..7 -> stay IDLE, bad_req pulse next cycle.
REQ-024 round_req in any non-IDLE state SHALL be ignored (no queueing, no bad_req).
REQ-025 LAUNCH: spin_start=1 for exactly this one cycle (cycle after round_req sampled); timer cleared; -> SPIN_WAIT.
REQ-026 SPIN_WAIT: spin_done=1 -> latched_result<=result_pos, -> SETTLE; else timer increments; timer reaching TIMEOUT_CYCLES-1 without spin_done -> ERROR.
REQ-027 spin_done and timeout on same edge: spin_done wins.
REQ-028 spin_done outside SPIN_WAIT SHALL be ignored; latched_result unchanged.
REQ-029 SETTLE: remain exactly SETTLE_CYCLES cycles, then EVAL.
REQ-030 EVAL: one cycle; win<=(hit_count!=0); -> UPDATE.
REQ-031 UPDATE: update_req=1 for this one cycle; -> HOLD. With spin_done sampled at edge S, update_req is high in cycle S+SETTLE_CYCLES+2.
REQ-032 HOLD: remain HOLD_CYCLES cycles, then DONE.
REQ-033 DONE: round_done=1 one cycle; round_cnt+1, wrapping 255->0; -> IDLE.
REQ-034 ERROR: timeout_err<=1; no update_req, no round_done; round_req ignored; exits only via abort or reset.
REQ-035 abort=1 in LAUNCH..HOLD -> IDLE next cycle, no further pulses, win<=0, round_cnt unchanged; abort in DONE ignored (round completes).
REQ-036 abort=1 in ERROR -> IDLE, timeout_err<=0; abort in IDLE is a no-op; abort beats round_req, spin_done and timeout on the same edge.
REQ-037 At most one of spin_start, update_req, round_done, bad_req SHALL be high in any cycle.

Reset
REQ-038 rst=0 at a clock edge SHALL force IDLE, clear all timers, and drive every output to 0 (round_cnt=0, latched_result=0, latched_bets=0, timeout_err=0) in the following cycle, regardless of state.
REQ-039 A reset mid-round SHALL produce no update_req or round_done; spin_start may not re-issue until a new round_req.

Verification (SETTLE_CYCLES=2, HOLD_CYCLES=3, TIMEOUT_CYCLES=20)
REQ-040 round_req, bet_count=2 at edge 0; spin_done with result_pos=5 at edge 4; hit_count=1 -> spin_start cycle 1, update_req cycle 8, win=1, latched_result=5, round_done cycle 12, round_cnt=1.
REQ-041 round_req with bet_count=0, then bet_count=5 -> bad_req one cycle each, spin_start never asserted, busy stays 0.
REQ-042 round accepted, no spin_done -> ERROR 20 cycles after LAUNCH, timeout_err=1, busy=0; later round_req ignored; abort -> timeout_err=0, IDLE.
REQ-043 abort during SETTLE -> IDLE next cycle, no update_req/round_done, win=0; extra round_req during SPIN_WAIT ignored.
REQ-044 256 completed rounds with hit_count=0 -> win=0 each round, round_cnt wraps to 0.
REQ-045 rst=0 in HOLD -> all outputs 0 next cycle, no round_done.
